// File: rtl/uart_pkg.sv
// uart_pkg: shared types and line-level constants for the UART transmitter and receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Encoding is shared with the transmitter so state dumps read the same on both sides.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA_BITS = 3'd2,
    STOP      = 3'd3,
    CLEANUP   = 3'd4
  } uart_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // True for the states in which a frame is on the wire.
  function automatic logic is_frame_state(input uart_state_t s);
    return (s == START) || (s == DATA_BITS) || (s == STOP);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, enable and received-word signals of the UART receiver.
// Latency: n/a (wiring only).
// Backpressure: none; received words are strobed once and never held off.
// Ports: i_Rx_serial / i_enable drive the receiver; o_Rx_b, o_Rx_DV, o_frame_err,
//        o_Rx_active are the receiver's results.
interface uart_rx_if #(
  parameter int m = 8
);
  import uart_pkg::*;

  logic         i_Rx_serial;
  logic         i_enable;
  logic [m-1:0] o_Rx_b;
  logic         o_Rx_DV;
  logic         o_frame_err;
  logic         o_Rx_active;

  // master: the side that owns the line and consumes the received words
  modport master (
    output i_Rx_serial, i_enable,
    input  o_Rx_b, o_Rx_DV, o_frame_err, o_Rx_active
  );

  // slave: the receiver itself
  modport slave (
    input  i_Rx_serial, i_enable,
    output o_Rx_b, o_Rx_DV, o_frame_err, o_Rx_active
  );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous serial line.
// Latency: 2 cycles from i_d to o_q.
// Backpressure: none.
// Ports: i_clk, i_rst_n (sync, active-low), i_d raw line, o_q synchronised line.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Reset to the idle level so a reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= LINE_IDLE;
      r_sync <= LINE_IDLE;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, mid-bit sampling, one-cycle valid / frame-error strobes.
// Latency: word strobed 3+HALF+(m+1)*CLKS_PER_BIT edges after the start bit is first sampled.
// Backpressure: none; the consumer must take o_Rx_b on the o_Rx_DV cycle (it holds until the next word).
// Ports: i_clk, i_rst_n (sync, active-low), rx_if (slave modport: line, enable, results).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int m            = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  uart_rx_if.slave   rx_if
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int IDX_W = $clog2(m);
  localparam int HALF  = CLKS_PER_BIT / 2 - 1;

  localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(m - 1);

  logic w_rx_s;

  uart_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [m-1:0]     r_shift;
  logic [m-1:0]     r_data;
  logic             r_dv;
  logic             r_err;
  logic             r_active;

  uart_state_t      w_next_state;
  logic [CNT_W-1:0] w_cnt_next;
  logic [IDX_W-1:0] w_idx_next;
  logic [m-1:0]     w_shift_next;
  logic [m-1:0]     w_data_next;
  logic             w_dv_next;
  logic             w_err_next;
  logic             w_active_next;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (rx_if.i_Rx_serial),
    .o_q     (w_rx_s)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_dv     <= 1'b0;
      r_err    <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_cnt_next;
      r_idx    <= w_idx_next;
      r_shift  <= w_shift_next;
      r_data   <= w_data_next;
      r_dv     <= w_dv_next;
      r_err    <= w_err_next;
      r_active <= w_active_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_data_next  = r_data;
    w_dv_next    = 1'b0;
    w_err_next   = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        w_idx_next = '0;
        if (rx_if.i_enable && (w_rx_s == LINE_START)) begin
          w_next_state = START;
        end
      end

      START: begin
        if (r_cnt == HALF_C) begin
          // Mid start bit: a line already back high was only a glitch.
          if (w_rx_s == LINE_START) begin
            w_next_state = DATA_BITS;
            w_cnt_next   = '0;
          end else begin
            w_next_state = IDLE;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      DATA_BITS: begin
        if (r_cnt == LAST_C) begin
          w_cnt_next          = '0;
          w_shift_next[r_idx] = w_rx_s;
          // Index holds at the last bit rather than wrapping.
          if (r_idx == LAST_IDX) begin
            w_next_state = STOP;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      STOP: begin
        if (r_cnt == LAST_C) begin
          w_cnt_next   = '0;
          w_next_state = CLEANUP;
          if (w_rx_s == LINE_IDLE) begin
            w_data_next = r_shift;
            w_dv_next   = 1'b1;
          end else begin
            w_err_next  = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      CLEANUP: begin
        // Wait out a break (line held low) before hunting for a new start bit.
        if (w_rx_s == LINE_IDLE) begin
          w_next_state = IDLE;
        end
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase

    // Disable aborts a frame silently: no strobe, last good word kept.
    if (!rx_if.i_enable && is_frame_state(r_state)) begin
      w_next_state = IDLE;
      w_data_next  = r_data;
      w_dv_next    = 1'b0;
      w_err_next   = 1'b0;
    end

    // Registered one edge after START is entered; drops on the strobe edge or an abort.
    w_active_next = is_frame_state(r_state) && is_frame_state(w_next_state);
  end

  assign rx_if.o_Rx_b      = r_data;
  assign rx_if.o_Rx_DV     = r_dv;
  assign rx_if.o_frame_err = r_err;
  assign rx_if.o_Rx_active = r_active;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CPB  = 4;
  localparam int HALF = CPB / 2 - 1;
  localparam int FRAME_LAT = 3 + HALF + 9 * CPB;  // start sample edge to strobe edge

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  uart_rx_if #(.m(8)) rx_if ();

  uart_rx #(.CLKS_PER_BIT(CPB), .m(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .rx_if   (rx_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled mid-cycle.
  logic       prev_act = 1'b0;
  int         rise_edge = -1, fall_edge = -1, rise_cnt = 0, act_cycles = 0;
  int         err_cnt = 0, err_edge = -1, both_cnt = 0;
  logic [7:0] dv_dat_q[$];
  int         dv_edge_q[$];

  always @(negedge clk) begin
    if (rx_if.o_Rx_active && !prev_act) begin
      rise_edge = cyc;
      rise_cnt  = rise_cnt + 1;
    end
    if (!rx_if.o_Rx_active && prev_act) fall_edge = cyc;
    if (rx_if.o_Rx_active) act_cycles = act_cycles + 1;
    prev_act = rx_if.o_Rx_active;
    if (rx_if.o_Rx_DV) begin
      dv_dat_q.push_back(rx_if.o_Rx_b);
      dv_edge_q.push_back(cyc);
    end
    if (rx_if.o_frame_err) begin
      err_cnt  = err_cnt + 1;
      err_edge = cyc;
    end
    if (rx_if.o_Rx_DV && rx_if.o_frame_err) both_cnt = both_cnt + 1;
  end

  // Call at a negedge; drives nbits of {stop, data, start}, each held CPB edges.
  task automatic drive_frame(input logic [7:0] d, input logic stop_b, input int nbits);
    logic [9:0] fr;
    fr = {stop_b, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx_if.i_Rx_serial = fr[i];
      if (i == 0) t0 = cyc + 1;
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_if.i_Rx_serial = 1'b1;
    rx_if.i_enable = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (rx_if.o_Rx_b !== 8'h00) begin n_bad++; $display("FAIL reset_rx_b got %h exp 00", rx_if.o_Rx_b); end
    n_cmp++; if (rx_if.o_Rx_DV !== 1'b0) begin n_bad++; $display("FAIL reset_dv got %b exp 0", rx_if.o_Rx_DV); end
    n_cmp++; if (rx_if.o_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", rx_if.o_frame_err); end
    n_cmp++; if (rx_if.o_Rx_active !== 1'b0) begin n_bad++; $display("FAIL reset_active got %b exp 0", rx_if.o_Rx_active); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    int b, e0;
    b = dv_dat_q.size();
    e0 = err_cnt;
    drive_frame(8'hA5, 1'b1, 10);
    repeat (6) @(negedge clk);
    n_cmp++; if (dv_dat_q.size() !== b + 1) begin n_bad++; $display("FAIL single_dv_count got %0d exp %0d", dv_dat_q.size() - b, 1); end
    if (dv_dat_q.size() > b) begin
      n_cmp++; if (dv_dat_q[b] !== 8'hA5) begin n_bad++; $display("FAIL single_data got %h exp a5", dv_dat_q[b]); end
      n_cmp++; if (dv_edge_q[b] !== t0 + FRAME_LAT) begin n_bad++; $display("FAIL single_dv_edge got %0d exp %0d", dv_edge_q[b], t0 + FRAME_LAT); end
    end
    n_cmp++; if (err_cnt !== e0) begin n_bad++; $display("FAIL single_no_err got %0d exp %0d", err_cnt, e0); end
    n_cmp++; if (rise_edge !== t0 + 3) begin n_bad++; $display("FAIL single_active_rise got %0d exp %0d", rise_edge, t0 + 3); end
    n_cmp++; if (fall_edge !== t0 + FRAME_LAT) begin n_bad++; $display("FAIL single_active_fall got %0d exp %0d", fall_edge, t0 + FRAME_LAT); end
    n_cmp++; if (rx_if.o_Rx_b !== 8'hA5) begin n_bad++; $display("FAIL single_rx_b got %h exp a5", rx_if.o_Rx_b); end
  endtask

  task automatic test_back_to_back();
    int b, e0, ta;
    b = dv_dat_q.size();
    e0 = err_cnt;
    drive_frame(8'h00, 1'b1, 10);
    ta = t0;
    drive_frame(8'hFF, 1'b1, 10);
    repeat (6) @(negedge clk);
    n_cmp++; if (dv_dat_q.size() !== b + 2) begin n_bad++; $display("FAIL b2b_dv_count got %0d exp 2", dv_dat_q.size() - b); end
    if (dv_dat_q.size() >= b + 2) begin
      n_cmp++; if (dv_dat_q[b] !== 8'h00) begin n_bad++; $display("FAIL b2b_first got %h exp 00", dv_dat_q[b]); end
      n_cmp++; if (dv_dat_q[b+1] !== 8'hFF) begin n_bad++; $display("FAIL b2b_second got %h exp ff", dv_dat_q[b+1]); end
      n_cmp++; if (dv_edge_q[b] !== ta + FRAME_LAT) begin n_bad++; $display("FAIL b2b_first_edge got %0d exp %0d", dv_edge_q[b], ta + FRAME_LAT); end
      n_cmp++; if (dv_edge_q[b+1] !== ta + 10 * CPB + FRAME_LAT) begin n_bad++; $display("FAIL b2b_second_edge got %0d exp %0d", dv_edge_q[b+1], ta + 10 * CPB + FRAME_LAT); end
    end
    n_cmp++; if (err_cnt !== e0) begin n_bad++; $display("FAIL b2b_no_err got %0d exp %0d", err_cnt, e0); end
    n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL pulse_exclusive got %0d exp 0", both_cnt); end
  endtask

  task automatic test_frame_err();
    int b, e0, r0;
    b = dv_dat_q.size();
    e0 = err_cnt;
    r0 = rise_cnt;
    drive_frame(8'h3C, 1'b0, 10);
    repeat (100) @(negedge clk);  // line stays low (break)
    n_cmp++; if (err_cnt !== e0 + 1) begin n_bad++; $display("FAIL ferr_count got %0d exp %0d", err_cnt - e0, 1); end
    n_cmp++; if (err_edge !== t0 + FRAME_LAT) begin n_bad++; $display("FAIL ferr_edge got %0d exp %0d", err_edge, t0 + FRAME_LAT); end
    n_cmp++; if (dv_dat_q.size() !== b) begin n_bad++; $display("FAIL ferr_no_dv got %0d exp 0", dv_dat_q.size() - b); end
    n_cmp++; if (rx_if.o_Rx_b !== 8'hFF) begin n_bad++; $display("FAIL ferr_rx_b_kept got %h exp ff", rx_if.o_Rx_b); end
    n_cmp++; if (rise_cnt !== r0 + 1) begin n_bad++; $display("FAIL ferr_no_restart got %0d exp %0d", rise_cnt - r0, 1); end
    rx_if.i_Rx_serial = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_glitch();
    int b, e0, a0;
    b = dv_dat_q.size();
    e0 = err_cnt;
    a0 = act_cycles;
    rx_if.i_Rx_serial = 1'b0;
    @(negedge clk);
    rx_if.i_Rx_serial = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++; if (dv_dat_q.size() !== b || err_cnt !== e0) begin n_bad++; $display("FAIL glitch_no_pulse got dv=%0d err=%0d exp 0 0", dv_dat_q.size() - b, err_cnt - e0); end
    n_cmp++; if (act_cycles - a0 > HALF + 1) begin n_bad++; $display("FAIL glitch_active_len got %0d exp <=%0d", act_cycles - a0, HALF + 1); end
    n_cmp++; if (rx_if.o_Rx_active !== 1'b0) begin n_bad++; $display("FAIL glitch_idle got %b exp 0", rx_if.o_Rx_active); end
  endtask

  // Aborts 0x5A after three data bits, by disable (use_rst=0) or reset (use_rst=1), then receives 0x81.
  task automatic test_abort(input logic use_rst);
    int b, e0;
    logic [7:0] exp_b;
    b = dv_dat_q.size();
    e0 = err_cnt;
    exp_b = use_rst ? 8'h00 : rx_if.o_Rx_b;
    drive_frame(8'h5A, 1'b1, 5);
    if (use_rst) rst_n = 1'b0; else rx_if.i_enable = 1'b0;
    @(negedge clk);
    n_cmp++; if (rx_if.o_Rx_active !== 1'b0) begin n_bad++; $display("FAIL abort%0d_active got %b exp 0", use_rst, rx_if.o_Rx_active); end
    n_cmp++; if (rx_if.o_Rx_b !== exp_b) begin n_bad++; $display("FAIL abort%0d_rx_b got %h exp %h", use_rst, rx_if.o_Rx_b, exp_b); end
    rst_n = 1'b1;
    rx_if.i_enable = 1'b1;
    rx_if.i_Rx_serial = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++; if (dv_dat_q.size() !== b || err_cnt !== e0) begin n_bad++; $display("FAIL abort%0d_no_pulse got dv=%0d err=%0d exp 0 0", use_rst, dv_dat_q.size() - b, err_cnt - e0); end
    drive_frame(8'h81, 1'b1, 10);
    repeat (6) @(negedge clk);
    n_cmp++; if (dv_dat_q.size() !== b + 1) begin n_bad++; $display("FAIL abort%0d_next_count got %0d exp 1", use_rst, dv_dat_q.size() - b); end
    n_cmp++; if (rx_if.o_Rx_b !== 8'h81) begin n_bad++; $display("FAIL abort%0d_next_data got %h exp 81", use_rst, rx_if.o_Rx_b); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
